maze_grid_memory: RTL and testbench
===================================

Name: maze_grid_memory

Overview:
- Responder end of the maze-cell access interface (X, Y, RD, WR, D_in, D_out) driven by the maze-solving rat controller.
- Holds a 16x16 single-bit maze grid: 1 = wall/visited, 0 = open.
- Serves single-cell reads with registered latency and single-cell writes.
- Includes a row-wide loader so a bench or host can install a maze, and a sweep engine that clears the grid.

Parameters:
- GRID_W, 16, cells per row (X range); fixed to match 4-bit X.
- GRID_H, 16, rows (Y range); fixed to match 4-bit Y.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- X  input  4  cell column for RD/WR.
- Y  input  4  cell row for RD/WR.
- RD  input  1  read strobe, one cell per cycle.
- WR  input  1  write strobe, one cell per cycle.
- D_in  input  1  write data for WR.
- D_out  output  1  registered read data.
- rd_valid  output  1  D_out holds the result of the RD issued one cycle earlier.
- ready  output  1  grid accepts RD/WR/load this cycle.
- clear_req  input  1  one-cycle pulse that starts a full-grid clear.
- load_valid  input  1  row-load request.
- load_row  input  4  row index for the load.
- load_data  input  16  row contents; bit i maps to cell (X=i, Y=load_row).

Behaviour:
- Storage: 16 rows x 16 bits; cell(X,Y) = mem[Y][X].
- Reset (rst=1 at edge):
  - D_out=0, rd_valid=0, ready=0.
  - Clear pointer=0; FSM enters CLEAR.
  - mem contents need not be reset directly; the CLEAR sweep zeroes them.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each cycle writes mem[ptr] <= 16'h0000 and increments ptr.
  - After row 15 is written, go to IDLE; ready=1 from the next cycle.
  - Duration is exactly 16 cycles.
  - ready=0 throughout; RD, WR and load_valid are ignored (no write, rd_valid=0).
- IDLE:
  - ready=1.
  - clear_req=1 -> ptr=0, go to CLEAR next cycle. Any RD/WR/load in that same cycle is still serviced.
- Read:
  - RD=1 in cycle N (IDLE) -> D_out=mem[Y][X] and rd_valid=1 in cycle N+1.
  - RD=0 -> rd_valid=0 next cycle and D_out holds its last value.
- Write: WR=1 in IDLE -> mem[Y][X] <= D_in at the edge; visible to a read issued the next cycle.
- Same-cycle RD and WR to the same cell: the read returns the old value (read-before-write).
- Load: load_valid=1 in IDLE -> mem[load_row] <= load_data. Single-cycle accept, no backpressure beyond ready.
- Load and WR in the same cycle, same row: the load is applied first, then the WR bit overrides its single cell. Different rows: both apply.
- clear_req asserted during CLEAR: restarts the sweep at ptr=0. The total clear then ends 16 cycles after the last clear_req.
- rst mid-CLEAR or mid-IDLE: returns to CLEAR with ptr=0 and all outputs at reset values.
- The bit read on a read-after-load returns the loaded bit.

Optional Feature:
- Macro: MAZE_WALL_BORDER_EN.
- Defined:
  - Any read with X=0, X=15, Y=0 or Y=15 returns D_out=1 regardless of mem, except cells (0,0) and (15,15), which read mem normally (start/exit).
  - Writes and loads still update mem.
- Undefined: all cells read mem directly.

Test Plan:
- Reset then idle: rst high 2 cycles, release -> ready=0 for 16 cycles, then 1; read (X=5,Y=7) -> rd_valid=1 next cycle, D_out=0.
- Write/read: WR (X=3,Y=9,D_in=1), next cycle RD same cell -> one cycle later D_out=1, rd_valid=1; RD (X=4,Y=9) -> D_out=0.
- Row load plus collision: load_row=2, load_data=16'hA5A5 while WR (X=0,Y=2,D_in=0) same cycle -> reads of X=0..15, Y=2 return pattern 16'hA5A4 (bit0 cleared).
- Read-before-write: cell (6,6)=0; RD and WR(D_in=1) same cycle -> D_out=0; following RD -> D_out=1.
- Clear mid-run: load all rows with 16'hFFFF, pulse clear_req, pulse again 5 cycles later -> ready low for 21 cycles total from the first pulse; afterwards all 256 cells read 0; RD during CLEAR gives rd_valid=0.
- With MAZE_WALL_BORDER_EN: empty grid, RD (X=0,Y=5) -> D_out=1; RD (0,0) -> 0; RD (15,15) -> 0; RD (7,7) -> 0. Without the macro, all four read 0.

Source files
------------

// File: rtl/maze_grid_memory.sv
// 16x16 single-bit maze grid serving the rat controller: registered single-cell reads,
// cell writes, whole-row loads and a 16-cycle clearing sweep. Optional macro: MAZE_WALL_BORDER_EN.
module maze_grid_memory #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  X,
  input  logic [3:0]  Y,
  input  logic        RD,
  input  logic        WR,
  input  logic        D_in,
  output logic        D_out,
  output logic        rd_valid,
  output logic        ready,
  input  logic        clear_req,
  input  logic        load_valid,
  input  logic [3:0]  load_row,
  input  logic [15:0] load_data
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        ptr_q, ptr_d;
  logic              d_out_q, d_out_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ready_q, ready_d;
  logic [GRID_W-1:0] mem_q [GRID_H];
  logic [GRID_W-1:0] mem_d [GRID_H];
  logic              border_hit;
  logic              rd_bit;

`ifdef MAZE_WALL_BORDER_EN
  // Outer ring reads as wall, except the start (0,0) and exit (15,15) cells.
  assign border_hit = ((X == 4'd0) || (X == 4'd15) || (Y == 4'd0) || (Y == 4'd15)) &&
                      !((X == 4'd0) && (Y == 4'd0)) &&
                      !((X == 4'd15) && (Y == 4'd15));
`else
  assign border_hit = 1'b0;
`endif

  // Read samples the pre-edge contents, giving read-before-write on collisions.
  assign rd_bit = border_hit | mem_q[Y][X];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    d_out_d    = d_out_q;
    rd_valid_d = 1'b0;
    mem_d      = mem_q;
    case (state_q)
      ST_CLEAR: begin
        mem_d[ptr_q] = '0;
        if (clear_req) begin
          ptr_d = 4'd0;
        end else begin
          ptr_d = ptr_q + 4'd1;
          if (ptr_q == 4'd15) state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (RD) begin
          d_out_d    = rd_bit;
          rd_valid_d = 1'b1;
        end
        // Row load lands first so a same-row WR overrides its single cell.
        if (load_valid) mem_d[load_row] = load_data;
        if (WR) mem_d[Y][X] = D_in;
        if (clear_req) begin
          ptr_d   = 4'd0;
          state_d = ST_CLEAR;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= 4'd0;
      d_out_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      d_out_q    <= d_out_d;
      rd_valid_q <= rd_valid_d;
      ready_q    <= ready_d;
    end
  end

  // Grid contents are zeroed by the sweep rather than by reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign D_out    = d_out_q;
  assign rd_valid = rd_valid_q;
  assign ready    = ready_q;

endmodule

// File: tb/tb_maze_grid_memory.sv
// Directed plus randomized bench for maze_grid_memory against a cell-array reference model.
// Honours MAZE_WALL_BORDER_EN when the design is built with it.
module tb_maze_grid_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  X = '0, Y = '0;
  logic        RD = 1'b0, WR = 1'b0, D_in = 1'b0;
  logic        D_out, rd_valid, ready;
  logic        clear_req = 1'b0;
  logic        load_valid = 1'b0;
  logic [3:0]  load_row = '0;
  logic [15:0] load_data = '0;

  maze_grid_memory dut (
    .clk(clk), .rst(rst), .X(X), .Y(Y), .RD(RD), .WR(WR), .D_in(D_in),
    .D_out(D_out), .rd_valid(rd_valid), .ready(ready), .clear_req(clear_req),
    .load_valid(load_valid), .load_row(load_row), .load_data(load_data)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] grid [16];
  int          clr_left = 0;
  logic        e_dout = 1'b0;
  bit          counting = 1'b0;
  int          low_cnt = 0;

  function automatic logic exp_cell(input logic [3:0] x, input logic [3:0] y);
`ifdef MAZE_WALL_BORDER_EN
    if ((x == 0 || x == 15 || y == 0 || y == 15) &&
        !(x == 0 && y == 0) && !(x == 15 && y == 15)) return 1'b1;
`endif
    return grid[y][x];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic zero_grid();
    for (int r = 0; r < 16; r++) grid[r] = '0;
  endtask

  task automatic step(input logic i_rst, input logic i_rd, input logic i_wr,
                      input logic [3:0] ix, input logic [3:0] iy, input logic idin,
                      input logic ild, input logic [3:0] ilrow, input logic [15:0] ildata,
                      input logic iclr);
    logic e_vld;
    rst = i_rst; RD = i_rd; WR = i_wr; X = ix; Y = iy; D_in = idin;
    load_valid = ild; load_row = ilrow; load_data = ildata; clear_req = iclr;
    @(posedge clk);
    #1;
    e_vld = 1'b0;
    if (i_rst) begin
      e_dout = 1'b0;
      clr_left = 16;
      zero_grid();
    end else if (clr_left == 0) begin
      e_vld = i_rd;
      if (i_rd) e_dout = exp_cell(ix, iy);
      if (ild) grid[ilrow] = ildata;
      if (i_wr) grid[iy][ix] = idin;
      if (iclr) begin
        zero_grid();
        clr_left = 16;
      end
    end else begin
      if (iclr) clr_left = 16;
      else clr_left--;
    end
    chk("ready", 32'(ready), 32'(clr_left == 0));
    chk("rd_valid", 32'(rd_valid), 32'(e_vld));
    chk("d_out", 32'(D_out), 32'(e_dout));
    if (counting && !ready) low_cnt++;
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
  endtask

  task automatic rd(input logic [3:0] x, input logic [3:0] y);
    step(0, 1, 0, x, y, 0, 0, 0, 16'h0, 0);
  endtask

  task automatic wr(input logic [3:0] x, input logic [3:0] y, input logic d);
    step(0, 0, 1, x, y, d, 0, 0, 16'h0, 0);
  endtask

  initial begin
    zero_grid();
    // Reset for two cycles, then the power-up sweep.
    step(1, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    repeat (16) nop();
    rd(5, 7);
    nop();

    // Write then read back.
    wr(3, 9, 1);
    rd(3, 9);
    rd(4, 9);

    // Row load colliding with a cell write in the same row.
    step(0, 0, 1, 0, 2, 0, 1, 2, 16'hA5A5, 0);
    for (int x = 0; x < 16; x++) rd(4'(x), 2);
`ifndef MAZE_WALL_BORDER_EN
    rd(0, 2);
    chk("row2_bit0", 32'(D_out), 32'd0);
    rd(2, 2);
    chk("row2_bit2", 32'(D_out), 32'd1);
`endif

    // Read-before-write on the same cell.
    step(0, 1, 1, 6, 6, 1, 0, 0, 16'h0, 0);
    rd(6, 6);

    // Fill the grid, then a clear that is restarted five cycles in.
    for (int r = 0; r < 16; r++) step(0, 0, 0, 0, 0, 0, 1, 4'(r), 16'hFFFF, 0);
    rd(8, 8);
    low_cnt = 0;
    counting = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 1);
    repeat (4) rd(1, 1);
    step(0, 1, 0, 1, 1, 0, 0, 0, 16'h0, 1);
    for (int i = 0; i < 60 && !ready; i++) nop();
    counting = 1'b0;
    chk("clear_ready_timeout", 32'(ready), 32'd1);
    chk("clear_low_cycles", 32'(low_cnt), 32'd21);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) rd(4'(x), 4'(y));

    // Border/corner cells on an empty grid.
    rd(0, 5);
    rd(0, 0);
    rd(15, 15);
    rd(7, 7);

    // Randomized traffic including occasional clears and resets.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 299) == 0), 1'($urandom), 1'($urandom),
           4'($urandom), 4'($urandom), 1'($urandom),
           ($urandom_range(0, 7) == 0), 4'($urandom), 16'($urandom),
           ($urandom_range(0, 99) == 0));
    end
    // Drain any clear in progress and read the whole grid.
    for (int i = 0; i < 20 && !ready; i++) nop();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) rd(4'(x), 4'(y));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
